refresh_executor: RTL and testbench
===================================

Name: refresh_executor

Overview:
- Consumer end of the refresh request/acknowledge pair. The refresh manager raises the level `refresh_needed` when the refresh interval expires; this block carries out the DRAM refresh and answers with a one-cycle `refresh_done`.
- Refresh sequence:
  1. Stall the normal scheduler and wait for it to drain.
  2. Precharge all banks if any bank is open.
  3. Issue NUM_REF auto-refresh commands, with tRP/tRFC timing enforced.
- Position: between the refresh manager, the command scheduler and the PHY command port.

Parameters:
- T_RP, 3, precharge-to-refresh wait in sys_clk cycles (>=1).
- T_RFC, 350, refresh-to-next-command wait in cycles (>=1).
- NUM_REF, 1, REF commands issued per request (1..15).
- NBANKS, 8, number of banks in the `bank_open` vector.
- CNT_W, 16, timing counter width; must hold max(T_RP, T_RFC).

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  synchronous, active-low reset.
- refresh_needed  in  1  level request from the refresh manager.
- refresh_done  out  1  one-cycle acknowledge to the refresh manager.
- hold_traffic  out  1  tells the scheduler to stop issuing new commands.
- traffic_idle  in  1  scheduler has no command in flight.
- bank_open  in  NBANKS  per-bank open-row flags.
- cmd_valid  out  1  command valid to the PHY.
- cmd_ready  in  1  PHY accepts the command.
- cmd  out  2  command code: 0 NOP, 1 PREA, 2 REF, 3 reserved/never driven.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset:
  - All state is updated on posedge sys_clk; all outputs are registered.
  - sys_rst_n=0 at an edge forces: state=IDLE, counter=0, ref_left=0, refresh_done=0, hold_traffic=0, cmd_valid=0, cmd=0, busy=0.
  - Reset applied mid-sequence aborts the sequence immediately; no `refresh_done` is generated.
- States: IDLE, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC, DONE.
- IDLE:
  - refresh_needed=1 -> DRAIN, with hold_traffic=1, busy=1, ref_left=NUM_REF.
- DRAIN:
  - hold_traffic stays 1.
  - traffic_idle=1 and bank_open!=0 -> PREA.
  - traffic_idle=1 and bank_open==0 -> REF (precharge skipped).
  - Otherwise wait with no timeout.
- PREA:
  - Drives cmd_valid=1, cmd=1.
  - Holds cmd valid and stable until cmd_valid&&cmd_ready at an edge.
  - Then cmd_valid=0, counter=T_RP-1 -> WAIT_RP.
- WAIT_RP:
  - Counter decrements once per cycle.
  - At counter==0 -> REF.
  - T_RP=1 gives exactly one idle cycle.
- REF:
  - Drives cmd_valid=1, cmd=2, with the same handshake as PREA.
  - On acceptance: counter=T_RFC-1, ref_left=ref_left-1 -> WAIT_RFC.
- WAIT_RFC:
  - At counter==0: ref_left!=0 -> REF; ref_left==0 -> DONE.
- DONE:
  - refresh_done=1 for exactly one cycle; hold_traffic cleared on the same edge.
  - Next state is IDLE unconditionally.
  - The manager clears `refresh_needed` on the edge that samples `refresh_done`, so IDLE does not retrigger.
  - If `refresh_needed` is still 1 in the first IDLE cycle (manager not yet cleared), the executor does not re-arm: a one-cycle lockout after DONE ignores the request.
- Handshake rules:
  - cmd_valid never drops, and cmd never changes, while waiting for cmd_ready.
  - cmd=0 whenever cmd_valid=0.
- refresh_needed is ignored outside IDLE; dropping it mid-sequence does not abort.
- bank_open is sampled only in the DRAIN exit cycle.
- Counters are unsigned; no wrap-around is possible within the parameter ranges.

Test Plan:
- Basic: reset, then refresh_needed=1, traffic_idle=1, bank_open=8'h04, cmd_ready=1 -> PREA accepted; 3 cycles later REF; 350 cycles later refresh_done pulses once; hold_traffic low the following cycle.
- Skip precharge: bank_open=0 -> first command is REF (cmd=2); cmd=1 never seen; done T_RFC cycles after REF acceptance.
- Backpressure: cmd_ready low for 5 cycles in PREA -> cmd_valid=1, cmd=1 held stable all 5 cycles; WAIT_RP starts only after acceptance.
- Drain: traffic_idle=0 for 10 cycles -> hold_traffic=1 and no cmd_valid until traffic_idle rises.
- NUM_REF=2, T_RFC=4 -> two REF commands exactly 4 cycles apart (acceptance to next valid); single refresh_done after the second wait.
- Reset mid WAIT_RFC (sys_rst_n=0 for one cycle) -> all outputs 0 next cycle, state IDLE, no refresh_done; a new request restarts from DRAIN.

Source files
------------

// File: rtl/refresh_executor.sv
// Refresh executor: drains the scheduler, precharges open banks and issues NUM_REF
// auto-refresh commands with tRP/tRFC spacing, then acknowledges with refresh_done.
module refresh_executor #(
  parameter int T_RP    = 3,
  parameter int T_RFC   = 350,
  parameter int NUM_REF = 1,
  parameter int NBANKS  = 8,
  parameter int CNT_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              refresh_needed,
  output logic              refresh_done,
  output logic              hold_traffic,
  input  logic              traffic_idle,
  input  logic [NBANKS-1:0] bank_open,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC, DONE
  } state_t;

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_PREA = 2'd1;
  localparam logic [1:0] CMD_REF  = 2'd2;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ref_left_q, ref_left_d;
  logic             lockout_q, lockout_d;
  logic             done_d, hold_d, valid_d, busy_d;
  logic [1:0]       cmd_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ref_left_d = ref_left_q;
    unique case (state_q)
      IDLE: begin
        if (refresh_needed && !lockout_q) begin
          state_d    = DRAIN;
          ref_left_d = 4'(NUM_REF);
        end
      end
      DRAIN: begin
        if (traffic_idle) state_d = (|bank_open) ? PREA : REF;
      end
      PREA: begin
        if (cmd_valid && cmd_ready) begin
          state_d = WAIT_RP;
          cnt_d   = CNT_W'(T_RP - 1);
        end
      end
      WAIT_RP: begin
        if (cnt_q == '0) state_d = REF;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      REF: begin
        if (cmd_valid && cmd_ready) begin
          state_d    = WAIT_RFC;
          cnt_d      = CNT_W'(T_RFC - 1);
          ref_left_d = ref_left_q - 4'd1;
        end
      end
      WAIT_RFC: begin
        if (cnt_q == '0) state_d = (ref_left_q != 4'd0) ? REF : DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    lockout_d = (state_q == DONE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    hold_d    = state_d inside {DRAIN, PREA, WAIT_RP, REF, WAIT_RFC};
    valid_d   = state_d inside {PREA, REF};
    cmd_d     = (state_d == PREA) ? CMD_PREA :
                (state_d == REF)  ? CMD_REF  : CMD_NOP;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      // NOTE: reset here covers all control state; there is no memory to clear.
      state_q      <= IDLE;
      cnt_q        <= '0;
      ref_left_q   <= '0;
      lockout_q    <= 1'b0;
      refresh_done <= 1'b0;
      hold_traffic <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd          <= CMD_NOP;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_left_q   <= ref_left_d;
      lockout_q    <= lockout_d;
      refresh_done <= done_d;
      hold_traffic <= hold_d;
      cmd_valid    <= valid_d;
      cmd          <= cmd_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_refresh_executor.sv
// Bench for refresh_executor: builds a per-cycle expected waveform from the refresh
// sequence rules (segment lengths) and drives randomized stimulus against it.
module tb_refresh_executor;

  localparam int A_RP = 3, A_RFC = 350, A_NREF = 1;
  localparam int B_RP = 1, B_RFC = 4,   B_NREF = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       refresh_needed, traffic_idle, cmd_ready;
  logic [7:0] bank_open;

  logic       a_done, a_hold, a_valid, a_busy;
  logic [1:0] a_cmd;
  logic       b_done, b_hold, b_valid, b_busy;
  logic [1:0] b_cmd;

  bit         sel;
  logic [5:0] obs;

  always #5 sys_clk = ~sys_clk;

  refresh_executor #(.T_RP(A_RP), .T_RFC(A_RFC), .NUM_REF(A_NREF), .NBANKS(8), .CNT_W(16)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .refresh_needed(refresh_needed),
    .refresh_done(a_done), .hold_traffic(a_hold), .traffic_idle(traffic_idle),
    .bank_open(bank_open), .cmd_valid(a_valid), .cmd_ready(cmd_ready),
    .cmd(a_cmd), .busy(a_busy));

  refresh_executor #(.T_RP(B_RP), .T_RFC(B_RFC), .NUM_REF(B_NREF), .NBANKS(8), .CNT_W(16)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .refresh_needed(refresh_needed),
    .refresh_done(b_done), .hold_traffic(b_hold), .traffic_idle(traffic_idle),
    .bank_open(bank_open), .cmd_valid(b_valid), .cmd_ready(cmd_ready),
    .cmd(b_cmd), .busy(b_busy));

  // Observed outputs packed as {busy, hold, done, valid, cmd}.
  assign obs = sel ? {b_busy, b_hold, b_done, b_valid, b_cmd}
                   : {a_busy, a_hold, a_done, a_valid, a_cmd};

  typedef struct {
    logic       rn, ti, rdy, rst;
    logic [7:0] bo;
    logic [5:0] exp;
  } step_t;

  step_t plan[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string scen;

  localparam logic [5:0] E_IDLE  = 6'b00_0_0_00;
  localparam logic [5:0] E_HOLD  = 6'b11_0_0_00;
  localparam logic [5:0] E_PREA  = 6'b11_0_1_01;
  localparam logic [5:0] E_REF   = 6'b11_0_1_10;
  localparam logic [5:0] E_DONE  = 6'b10_1_0_00;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (busy,hold,done,valid,cmd)", tag, got, want);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rn, input logic ti, input logic rdy, input logic [7:0] bo,
                      input logic [5:0] exp, input logic rst);
    step_t s;
    s.rn = rn; s.ti = ti; s.rdy = rdy; s.bo = bo; s.exp = exp; s.rst = rst;
    plan.push_back(s);
  endtask

  // Expected waveform of one request, as a sequence of segments whose lengths
  // follow from drain delay, handshake stalls and the tRP/tRFC wait times.
  task automatic build(input int t_rp, input int t_rfc, input int num_ref, input int d,
                       input logic [7:0] bo, input int sp, input int sr,
                       input bit lock_test, input bit noise, input int abort_at);
    plan.delete();
    push(1'b1, rbit(), rbit(), 8'($urandom), E_IDLE, 1'b0);
    for (int j = 0; j <= d; j++)
      push(noise ? rbit() : 1'b1, j == d, rbit(), (j == d) ? bo : 8'($urandom), E_HOLD, 1'b0);
    if (bo != 8'h00) begin
      for (int j = 0; j <= sp; j++)
        push(noise ? rbit() : 1'b1, rbit(), j == sp, 8'($urandom), E_PREA, 1'b0);
      for (int j = 0; j < t_rp; j++)
        push(noise ? rbit() : 1'b1, rbit(), rbit(), 8'($urandom), E_HOLD, 1'b0);
    end
    for (int r = 0; r < num_ref; r++) begin
      for (int j = 0; j <= sr; j++)
        push(noise ? rbit() : 1'b1, rbit(), j == sr, 8'($urandom), E_REF, 1'b0);
      for (int j = 0; j < t_rfc; j++) begin
        if (r == 0 && j == abort_at) begin
          push(1'b0, rbit(), rbit(), 8'($urandom), E_HOLD, 1'b1);
          push(1'b0, rbit(), rbit(), 8'($urandom), E_IDLE, 1'b0);
          return;
        end
        push(noise ? rbit() : 1'b1, rbit(), rbit(), 8'($urandom), E_HOLD, 1'b0);
      end
    end
    push(1'b1, rbit(), rbit(), 8'($urandom), E_DONE, 1'b0);
    push(lock_test, rbit(), rbit(), 8'($urandom), E_IDLE, 1'b0);
    push(1'b0, rbit(), rbit(), 8'($urandom), E_IDLE, 1'b0);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_plan();
    foreach (plan[i]) begin
      check($sformatf("%s[%0d]", scen, i), obs, plan[i].exp);
      sys_rst_n      = ~plan[i].rst;
      refresh_needed = plan[i].rn;
      traffic_idle   = plan[i].ti;
      cmd_ready      = plan[i].rdy;
      bank_open      = plan[i].bo;
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic reset_both();
    sys_rst_n = 1'b0;
    refresh_needed = 1'b1; traffic_idle = 1'b1; cmd_ready = 1'b1; bank_open = 8'hff;
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_a", {a_busy, a_hold, a_done, a_valid, a_cmd}, E_IDLE);
    check("reset_b", {b_busy, b_hold, b_done, b_valid, b_cmd}, E_IDLE);
    sys_rst_n = 1'b1;
    refresh_needed = 1'b0;
  endtask

  task automatic rand_scen(input int t_rp, input int t_rfc, input int nref, input int k);
    logic [7:0] bo;
    bo = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    scen = $sformatf("rand%0d", k);
    build(t_rp, t_rfc, nref, $urandom_range(0, 6), bo, $urandom_range(0, 4),
          $urandom_range(0, 4), rbit(), 1'b1, -1);
    run_plan();
  endtask

  initial begin
    sel = 1'b0;
    reset_both();

    scen = "basic";     build(A_RP, A_RFC, A_NREF, 0,  8'h04, 0, 0, 1'b0, 1'b0, -1); run_plan();
    scen = "skip_prea"; build(A_RP, A_RFC, A_NREF, 0,  8'h00, 0, 0, 1'b0, 1'b0, -1); run_plan();
    scen = "backpress"; build(A_RP, A_RFC, A_NREF, 0,  8'h81, 5, 3, 1'b0, 1'b0, -1); run_plan();
    scen = "drain";     build(A_RP, A_RFC, A_NREF, 10, 8'h04, 0, 0, 1'b0, 1'b1, -1); run_plan();
    scen = "abort_a";   build(A_RP, A_RFC, A_NREF, 2,  8'h20, 1, 0, 1'b0, 1'b0, 100); run_plan();
    scen = "restart_a"; build(A_RP, A_RFC, A_NREF, 1,  8'h02, 0, 1, 1'b0, 1'b0, -1); run_plan();
    for (int k = 0; k < 2; k++) rand_scen(A_RP, A_RFC, A_NREF, k);

    sel = 1'b1;
    reset_both();
    scen = "two_ref";   build(B_RP, B_RFC, B_NREF, 0, 8'h10, 0, 0, 1'b0, 1'b0, -1); run_plan();
    scen = "lockout";   build(B_RP, B_RFC, B_NREF, 0, 8'h00, 0, 0, 1'b1, 1'b0, -1); run_plan();
    scen = "abort_b";   build(B_RP, B_RFC, B_NREF, 1, 8'h01, 0, 2, 1'b0, 1'b0, 2);  run_plan();
    scen = "restart_b"; build(B_RP, B_RFC, B_NREF, 3, 8'h40, 2, 1, 1'b1, 1'b1, -1); run_plan();
    for (int k = 0; k < 12; k++) rand_scen(B_RP, B_RFC, B_NREF, k + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
